// File: rtl/dmem_ctrl.sv
// Data-memory controller: byte-enable RAM, MMIO window (channels, CNT, CTRL) and a zeroing scrub engine.
// Reads respond READ_LATENCY cycles after acceptance, fully pipelined; writes produce no response.
// req_ready is registered and drops for the whole scrub; responses are never stalled.
module dmem_ctrl #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 12,
    parameter int DEPTH        = 3072,
    parameter int READ_LATENCY = 1,
    parameter int IO_BASE      = 4032,
    parameter int NUM_IO       = 4,
    parameter int INIT_SCRUB   = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         req_valid,
    input  logic                         req_wren,
    input  logic [ADDR_WIDTH-1:0]        req_addr,
    input  logic [DATA_WIDTH-1:0]        req_data,
    input  logic [DATA_WIDTH/8-1:0]      req_be,
    output logic                         req_ready,
    output logic                         resp_valid,
    output logic [DATA_WIDTH-1:0]        resp_data,
    output logic [NUM_IO*DATA_WIDTH-1:0] io_out,
    input  logic [NUM_IO*DATA_WIDTH-1:0] io_in,
    output logic                         err,
    output logic                         scrub_busy
);

    localparam int NB        = DATA_WIDTH / 8;
    localparam int RAW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_ADDR  = IO_BASE + NUM_IO;
    localparam int CTRL_ADDR = IO_BASE + NUM_IO + 1;

    typedef enum logic {IDLE, SCRUB} state_t;

    state_t                  state;
    logic                    init_pend;
    logic [RAW-1:0]          scrub_addr;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   cnt;
    logic [31:0]             addr32;
    logic [RAW-1:0]          ram_idx;
    logic                    acc, rd_acc, wr_acc;
    logic                    in_ram, in_io, is_cnt, is_ctrl, unmapped;
    logic [DATA_WIDTH-1:0]   rd_src;
    logic [READ_LATENCY-1:0] pipe_vld;
    logic [DATA_WIDTH-1:0]   pipe_dat [READ_LATENCY];

    assign addr32   = 32'(req_addr);
    assign ram_idx  = req_addr[RAW-1:0];
    assign acc      = req_valid && req_ready;
    assign rd_acc   = acc && !req_wren;
    assign wr_acc   = acc && req_wren;
    assign in_ram   = addr32 < 32'(DEPTH);
    assign in_io    = (addr32 >= 32'(IO_BASE)) && (addr32 < 32'(IO_BASE + NUM_IO));
    assign is_cnt   = addr32 == 32'(CNT_ADDR);
    assign is_ctrl  = addr32 == 32'(CTRL_ADDR);
    assign unmapped = !(in_ram || in_io || is_cnt || is_ctrl);

    always_comb begin
        rd_src = '0;
        if (in_ram) begin
            rd_src = mem[ram_idx];
        end else if (is_cnt) begin
            rd_src = cnt;
        end else if (is_ctrl) begin
            rd_src[1:0] = {scrub_busy, err};
        end else begin
            for (int k = 0; k < NUM_IO; k++) begin
                if (addr32 == 32'(IO_BASE + k)) rd_src = io_in[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Storage has no reset; contents are only defined once a scrub completes.
    always_ff @(posedge clock) begin
        if (state == SCRUB) begin
            mem[scrub_addr] <= '0;
        end else if (wr_acc && in_ram) begin
            for (int b = 0; b < NB; b++) begin
                if (req_be[b]) mem[ram_idx][b*8 +: 8] <= req_data[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            init_pend  <= (INIT_SCRUB != 0);
            req_ready  <= (INIT_SCRUB == 0);
            scrub_busy <= 1'b0;
            scrub_addr <= '0;
            err        <= 1'b0;
            io_out     <= '0;
            cnt        <= '0;
        end else begin
            cnt       <= cnt + 1'b1;
            init_pend <= 1'b0;
            // Setting beats clearing when both happen on the same edge.
            if (acc && unmapped)
                err <= 1'b1;
            else if (wr_acc && is_ctrl && req_data[1])
                err <= 1'b0;
            if (wr_acc) begin
                for (int k = 0; k < NUM_IO; k++) begin
                    if (addr32 == 32'(IO_BASE + k)) io_out[k*DATA_WIDTH +: DATA_WIDTH] <= req_data;
                end
            end
            case (state)
                IDLE: begin
                    if (init_pend || (wr_acc && is_ctrl && req_data[0])) begin
                        state      <= SCRUB;
                        req_ready  <= 1'b0;
                        scrub_busy <= 1'b1;
                        scrub_addr <= '0;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                SCRUB: begin
                    scrub_addr <= scrub_addr + 1'b1;
                    if (scrub_addr == RAW'(DEPTH - 1)) begin
                        state      <= IDLE;
                        req_ready  <= 1'b1;
                        scrub_busy <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Data stages load only behind a valid token, so the last stage holds the previous response.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pipe_vld <= '0;
            for (int i = 0; i < READ_LATENCY; i++) pipe_dat[i] <= '0;
        end else begin
            pipe_vld[0] <= rd_acc;
            if (rd_acc) pipe_dat[0] <= rd_src;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                if (pipe_vld[i-1]) pipe_dat[i] <= pipe_dat[i-1];
            end
        end
    end

    assign resp_valid = pipe_vld[READ_LATENCY-1];
    assign resp_data  = pipe_dat[READ_LATENCY-1];

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with READ_LATENCY=3 and the default 3072-word RAM with power-on scrub.
module tb_dmem_ctrl;

    localparam int DW    = 32;
    localparam int AW    = 12;
    localparam int DEPTH = 3072;
    localparam int RL    = 3;
    localparam int IOB   = 4032;
    localparam int NIO   = 4;
    localparam int CNTA  = IOB + NIO;
    localparam int CTRLA = IOB + NIO + 1;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_wren = 1'b0;
    logic [AW-1:0]     req_addr = '0;
    logic [DW-1:0]     req_data = '0;
    logic [DW/8-1:0]   req_be = '0;
    logic              req_ready;
    logic              resp_valid;
    logic [DW-1:0]     resp_data;
    logic [NIO*DW-1:0] io_out;
    logic [NIO*DW-1:0] io_in = '0;
    logic              err;
    logic              scrub_busy;

    int checks = 0;
    int failures = 0;
    logic [DW-1:0] tbcnt;
    logic [DW-1:0] cnt_exp;

    always #5 clock = ~clock;

    always @(posedge clock or negedge reset) begin
        if (!reset) tbcnt <= '0;
        else        tbcnt <= tbcnt + 1'b1;
    end

    dmem_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .READ_LATENCY(RL),
        .IO_BASE(IOB), .NUM_IO(NIO), .INIT_SCRUB(1)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_wren(req_wren), .req_addr(req_addr),
        .req_data(req_data), .req_be(req_be), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .io_out(io_out), .io_in(io_in), .err(err), .scrub_busy(scrub_busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic req(input logic wr, input int addr, input logic [DW-1:0] d, input logic [3:0] be);
        req_valid = 1'b1;
        req_wren  = wr;
        req_addr  = AW'(addr);
        req_data  = d;
        req_be    = be;
        tick();
        req_valid = 1'b0;
        req_wren  = 1'b0;
    endtask

    task automatic rd(input int addr, input logic [DW-1:0] exp, input string tag);
        req(1'b0, addr, '0, 4'h0);
        tick();
        tick();
        check({tag, "_vld"}, 64'(resp_valid), 64'd1);
        check(tag, 64'(resp_data), 64'(exp));
    endtask

    task automatic chk_reset(input string tag);
        check({tag, "_ready"}, 64'(req_ready), 64'd0);
        check({tag, "_rvalid"}, 64'(resp_valid), 64'd0);
        check({tag, "_rdata"}, 64'(resp_data), 64'd0);
        check({tag, "_ioout0"}, 64'(io_out == '0), 64'd1);
        check({tag, "_err"}, 64'(err), 64'd0);
        check({tag, "_busy"}, 64'(scrub_busy), 64'd0);
    endtask

    task automatic measure_scrub(input string tag);
        int n = 0;
        int bad = 0;
        for (int i = 0; i < 5000; i++) begin
            tick();
            if (scrub_busy) begin
                n++;
                if (req_ready) bad++;
            end else if (n > 0) begin
                break;
            end
        end
        check({tag, "_len"}, 64'(n), 64'(DEPTH));
        check({tag, "_ready_low"}, 64'(bad), 64'd0);
        check({tag, "_ready_after"}, 64'(req_ready), 64'd1);
    endtask

    initial begin
        tick();
        tick();
        tick();
        chk_reset("reset");
        reset = 1'b1;
        measure_scrub("init_scrub");
        rd(5, 32'h0, "scrubbed_addr5");

        // byte-enable merge, read immediately after the write
        req(1'b1, 10, 32'hDEADBEEF, 4'b1111);
        req(1'b1, 10, 32'h000000AA, 4'b0001);
        rd(10, 32'hDEADBEAA, "be_merge");
        req(1'b1, 11, 32'h11223344, 4'b1111);
        req(1'b1, 11, 32'hAABBCCDD, 4'b0110);
        rd(11, 32'h11BBCC44, "be_middle");

        // back-to-back reads, in order, one-cycle valid pulses
        req(1'b1, 1, 32'h11, 4'hF);
        req(1'b1, 2, 32'h22, 4'hF);
        req(1'b1, 3, 32'h33, 4'hF);
        req_valid = 1'b1; req_wren = 1'b0; req_addr = AW'(1); tick();
        req_addr = AW'(2); tick();
        check("pipe_lat_early", 64'(resp_valid), 64'd0);
        req_addr = AW'(3); tick();
        req_valid = 1'b0;
        check("pipe_v1", 64'(resp_valid), 64'd1);
        check("pipe_d1", 64'(resp_data), 64'h11);
        tick();
        check("pipe_d2", 64'(resp_data), 64'h22);
        tick();
        check("pipe_d3", 64'(resp_data), 64'h33);
        tick();
        check("pipe_v_drop", 64'(resp_valid), 64'd0);
        check("pipe_hold", 64'(resp_data), 64'h33);

        // MMIO channels and cycle counter
        req(1'b1, IOB + 2, 32'h5, 4'h0);
        check("io_out2", 64'(io_out[2*DW +: DW]), 64'h5);
        check("io_out1_untouched", 64'(io_out[1*DW +: DW]), 64'h0);
        io_in[1*DW +: DW] = 32'h77;
        rd(IOB + 1, 32'h77, "io_in1");
        cnt_exp = tbcnt;
        rd(CNTA, cnt_exp, "cnt_read");

        // RAM boundary words, then unmapped accesses and err handling
        req(1'b1, 0, 32'hCAFE, 4'hF);
        req(1'b1, DEPTH - 1, 32'h12345678, 4'hF);
        rd(DEPTH - 1, 32'h12345678, "ram_last");
        check("err_clean", 64'(err), 64'd0);
        rd(3500, 32'h0, "unmapped_rd");
        check("err_set_rd", 64'(err), 64'd1);
        req(1'b1, CTRLA, 32'h2, 4'h0);
        check("err_clear", 64'(err), 64'd0);
        rd(CTRLA, 32'h0, "ctrl_rd");
        req(1'b1, CTRLA + 1, 32'h9, 4'hF);
        check("err_set_wr", 64'(err), 64'd1);
        rd(DEPTH, 32'h0, "unmapped_depth");

        // read in flight across scrub start; CTRL=3 clears err and starts scrub
        req(1'b0, 10, '0, 4'h0);
        req(1'b1, CTRLA, 32'h3, 4'h0);
        check("ctrl3_err", 64'(err), 64'd0);
        check("ctrl3_busy", 64'(scrub_busy), 64'd1);
        check("ctrl3_ready", 64'(req_ready), 64'd0);
        tick();
        check("inflight_vld", 64'(resp_valid), 64'd1);
        check("inflight_dat", 64'(resp_data), 64'hDEADBEAA);
        repeat (100) tick();
        check("mid_scrub_busy", 64'(scrub_busy), 64'd1);
        reset = 1'b0;
        #1;
        chk_reset("midreset");
        tick();
        tick();
        chk_reset("midreset_hold");
        reset = 1'b1;
        measure_scrub("rescrub");
        rd(0, 32'h0, "rescrub_first");
        rd(10, 32'h0, "rescrub_mid");
        rd(DEPTH - 1, 32'h0, "rescrub_last");
        check("io_out2_after_reset", 64'(io_out[2*DW +: DW]), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
